// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int INSTR_BYTES = 4;

  // One fetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_pkt_t;

  // Force a byte PC onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of {pc, instr} that absorbs the ROM latency under backpressure.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  fetch_pkt_t i_push_pkt,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic [1:0] o_count,
  output fetch_pkt_t o_head
);

  fetch_pkt_t r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // Entry storage; written on push, never read while the FIFO is empty.
  // NOTE: the data array is deliberately not reset -- occupancy alone
  // decides validity, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_pkt;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/rom_fetch_stage.sv
// Instruction fetch stage in front of a 1-cycle-latency synchronous ROM.
// Holds the fetch PC, tracks the single in-flight read, and presents
// {pc, instr} to decode through a two-entry skid FIFO or a direct bypass.
module rom_fetch_stage #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          DATA_WIDTH = 32,  // must match fetch_pkg::DATA_WIDTH
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [DATA_WIDTH-1:0] out_instr
);

  import fetch_pkg::*;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;

  logic [1:0]      w_occ;
  fetch_pkt_t      w_head;
  fetch_pkt_t      w_ret_pkt;
  logic            w_fifo_nonempty;
  logic            w_pop;
  logic [2:0]      w_pending;
  logic            w_issue;
  logic            w_push;

  // The ROM always sees the current fetch PC; the read only matters on issue.
  assign rom_addr        = r_fetch_pc[ADDR_WIDTH+1:2];
  assign w_fifo_nonempty = (w_occ != 2'd0);
  assign w_ret_pkt       = '{pc: r_inflight_pc, instr: rom_data};

  // Present the FIFO head first, otherwise bypass the returning ROM word.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (w_fifo_nonempty) begin
      out_valid = 1'b1;
      out_pc    = w_head.pc;
      out_instr = w_head.instr;
    end else if (r_inflight) begin
      out_valid = 1'b1;
      out_pc    = r_inflight_pc;
      out_instr = rom_data;
    end
  end

  // Issue only while buffered plus in-flight work, net of this cycle's pop,
  // leaves room for the word that will come back next cycle.
  assign w_pop     = out_valid & out_ready;
  assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = !redirect_valid && (w_pending < 3'd2);

  // Returning data goes to the FIFO unless decode took it via the bypass.
  assign w_push    = r_inflight && !(w_pop && !w_fifo_nonempty);

  // Fetch PC and in-flight tracking; redirect squashes the outstanding read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= align_pc(redirect_pc);
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_pkt (w_ret_pkt),
    .i_pop      (w_pop && w_fifo_nonempty),
    .i_flush    (redirect_valid),
    .o_count    (w_occ),
    .o_head     (w_head)
  );

endmodule
